// File: rtl/halfword_load_unit_if.sv
// Data-memory read port used by the half-word load unit.
// The master side issues requests and the slave side returns data.
interface halfword_load_unit_if;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady;
    logic [31:0] memRdata;

    modport master (
        output memReq,
        output memAddr,
        input  memReady,
        input  memRdata
    );

    modport slave (
        input  memReq,
        input  memAddr,
        output memReady,
        output memRdata
    );
endinterface

// File: rtl/halfword_load_unit.sv
// Half-word load sequencer: issues one aligned word read per LH/LHU, selects the half,
// and reports completion, misalignment, or a memory timeout as single-cycle pulses.
module halfword_load_unit #(
    parameter int TIMEOUT    = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        startLoad,
    input  logic [31:0]                 address,
    input  logic                        extSign,
    halfword_load_unit_if.master        memBus,
    output logic [15:0]                 halfWord,
    output logic                        ExtHalf,
    output logic                        loadDone,
    output logic                        busy,
    output logic                        loadErr,
    output logic                        errCode
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  waitCnt_r;
    logic [31:1] addrLatched_r;
    logic        extLatched_r;
    logic        memReq_r;
    logic [31:0] memAddr_r;

    function automatic logic [15:0] selectHalf(input logic [31:0] word, input logic addrBit1);
        logic upper;
        upper = addrBit1 ^ BIG_ENDIAN;
        if (upper) begin
            return word[31:16];
        end else begin
            return word[15:0];
        end
    endfunction

    assign memBus.memReq  = memReq_r;
    assign memBus.memAddr = memAddr_r;

    // Load FSM; every output is registered so it changes together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            waitCnt_r     <= 8'd0;
            addrLatched_r <= 31'd0;
            extLatched_r  <= 1'b0;
            memReq_r      <= 1'b0;
            memAddr_r     <= 32'd0;
            halfWord      <= 16'd0;
            ExtHalf       <= 1'b0;
            loadDone      <= 1'b0;
            busy          <= 1'b0;
            loadErr       <= 1'b0;
            errCode       <= 1'b0;
        end else begin
            loadDone <= 1'b0;
            loadErr  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (startLoad && address[0]) begin
                        state_r <= ERR;
                        loadErr <= 1'b1;
                        errCode <= 1'b0;
                    end else if (startLoad) begin
                        state_r       <= REQ;
                        addrLatched_r <= address[31:1];
                        extLatched_r  <= extSign;
                        waitCnt_r     <= 8'd0;
                        memReq_r      <= 1'b1;
                        memAddr_r     <= {address[31:2], 2'b00};
                        busy          <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    // A ready response takes priority over an expiring wait counter.
                    if (memBus.memReady) begin
                        state_r   <= DONE;
                        halfWord  <= selectHalf(memBus.memRdata, addrLatched_r[1]);
                        ExtHalf   <= extLatched_r;
                        loadDone  <= 1'b1;
                        memReq_r  <= 1'b0;
                        memAddr_r <= 32'd0;
                        busy      <= 1'b0;
                    end else if (waitCnt_r == WAIT_LAST) begin
                        state_r   <= ERR;
                        loadErr   <= 1'b1;
                        errCode   <= 1'b1;
                        memReq_r  <= 1'b0;
                        memAddr_r <= 32'd0;
                        busy      <= 1'b0;
                    end else begin
                        waitCnt_r <= waitCnt_r + 8'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                ERR: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    memReq_r  <= 1'b0;
                    memAddr_r <= 32'd0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halfword_load_unit.sv
// Scoreboard bench for halfword_load_unit: expected completions are queued when a load
// is launched and compared when the unit pulses loadDone or loadErr.
module tb_halfword_load_unit;

    localparam int TO = 4;
    localparam bit BE = 1'b0;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        startLoad = 1'b0;
    logic [31:0] address   = 32'd0;
    logic        extSign   = 1'b0;
    logic [15:0] halfWord;
    logic        ExtHalf;
    logic        loadDone;
    logic        busy;
    logic        loadErr;
    logic        errCode;

    halfword_load_unit_if memBus();

    halfword_load_unit #(.TIMEOUT(TO), .BIG_ENDIAN(BE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .startLoad (startLoad),
        .address   (address),
        .extSign   (extSign),
        .memBus    (memBus),
        .halfWord  (halfWord),
        .ExtHalf   (ExtHalf),
        .loadDone  (loadDone),
        .busy      (busy),
        .loadErr   (loadErr),
        .errCode   (errCode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        isErr;
        logic        code;
        logic [15:0] half;
        logic        ext;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    logic [15:0] modelHalf = 16'd0;
    logic        modelExt  = 1'b0;
    int          nCompared   = 0;
    int          nMismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer plus per-cycle bus invariants.
    always @(negedge clk) begin
        if (memBus.memReq == 1'b0) begin
            checkVal("memAddrZeroIdle", memBus.memAddr, 32'd0);
        end
        checkVal("busyMatchesReq", {31'd0, busy}, {31'd0, memBus.memReq});
        if (loadDone || loadErr) begin
            if (expQ.size() == 0) begin
                checkVal("unexpectedPulse", {30'd0, loadDone, loadErr}, 32'd0);
            end else begin
                monE = expQ.pop_front();
                checkVal("loadErr", {31'd0, loadErr}, {31'd0, monE.isErr});
                checkVal("loadDone", {31'd0, loadDone}, {31'd0, ~monE.isErr});
                if (monE.isErr) begin
                    checkVal("errCode", {31'd0, errCode}, {31'd0, monE.code});
                end
                checkVal("halfWord", {16'd0, halfWord}, {16'd0, monE.half});
                checkVal("ExtHalf", {31'd0, ExtHalf}, {31'd0, monE.ext});
            end
        end
    end

    // Call between clock edges; startLoad is sampled on the next rising edge.
    task automatic runLoad(input logic [31:0] addr, input logic ext, input logic [31:0] rdata,
                           input int readyAt, input bit ghost);
        exp_t e;
        int   expLat;
        int   expBusy;
        int   edges;
        int   busyCnt;
        int   reqCnt;
        bit   seen;
        e.code = 1'b0;
        if (addr[0]) begin
            e.isErr = 1'b1;
            expLat  = 1;
            expBusy = 0;
        end else if (readyAt >= 0 && readyAt < TO) begin
            e.isErr   = 1'b0;
            expLat    = readyAt + 2;
            expBusy   = readyAt + 1;
            modelHalf = (addr[1] ^ BE) ? rdata[31:16] : rdata[15:0];
            modelExt  = ext;
        end else begin
            e.isErr = 1'b1;
            e.code  = 1'b1;
            expLat  = TO + 1;
            expBusy = TO;
        end
        e.half = modelHalf;
        e.ext  = modelExt;
        expQ.push_back(e);

        startLoad        = 1'b1;
        address          = addr;
        extSign          = ext;
        memBus.memReady  = 1'b0;
        memBus.memRdata  = rdata;
        edges   = 0;
        busyCnt = 0;
        reqCnt  = 0;
        seen    = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (ghost && edges == 1) begin
                startLoad = 1'b1;
                address   = 32'h0000_4444;
                extSign   = ~ext;
            end else begin
                startLoad = 1'b0;
                address   = 32'hFFFF_FFFF;
            end
            memBus.memReady = ((edges - 1) == readyAt);
            @(negedge clk);
            if (busy) busyCnt++;
            if (memBus.memReq) reqCnt++;
            if (edges == 1 && !addr[0]) begin
                checkVal("memAddrReq", memBus.memAddr, {addr[31:2], 2'b00});
            end
            if (loadDone || loadErr) seen = 1'b1;
        end
        checkVal("pulseSeen", {31'd0, seen}, 32'd1);
        checkVal("latency", 32'(edges), 32'(expLat));
        checkVal("busyCycles", 32'(busyCnt), 32'(expBusy));
        checkVal("reqCycles", 32'(reqCnt), 32'(expBusy));
        memBus.memReady = 1'b0;
        startLoad       = 1'b0;
    endtask

    initial begin
        memBus.memReady = 1'b0;
        memBus.memRdata = 32'd0;
        #3;
        checkVal("rstMemReq", {31'd0, memBus.memReq}, 32'd0);
        checkVal("rstHalfWord", {16'd0, halfWord}, 32'd0);
        checkVal("rstOutputs", {27'd0, ExtHalf, loadDone, busy, loadErr, errCode}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        @(posedge clk); #1;
        runLoad(32'h0000_1002, 1'b1, 32'h8001_1234, 0, 1'b0);
        @(posedge clk); #1;
        runLoad(32'h0000_2000, 1'b0, 32'hABCD_F00F, 3, 1'b0);
        @(posedge clk); #1;
        runLoad(32'h0000_3001, 1'b1, 32'h5555_AAAA, 0, 1'b0);
        @(posedge clk); #1;
        runLoad(32'h0000_4000, 1'b1, 32'h1111_2222, -1, 1'b0);
        @(posedge clk); #1;
        runLoad(32'h0000_4002, 1'b1, 32'h7FFE_0001, TO - 1, 1'b0);
        @(posedge clk); #1;
        runLoad(32'h0000_5000, 1'b0, 32'h1234_5678, 1, 1'b1);

        // memReady while idle must not disturb anything
        @(posedge clk); #1;
        memBus.memReady = 1'b1;
        memBus.memRdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        memBus.memReady = 1'b0;
        checkVal("idleReadyHold", {16'd0, halfWord}, {16'd0, modelHalf});

        // reset in the middle of a request abandons it
        @(posedge clk); #1;
        startLoad = 1'b1;
        address   = 32'h0000_7000;
        extSign   = 1'b1;
        @(posedge clk); #1;
        startLoad = 1'b0;
        @(negedge clk);
        checkVal("reqBeforeReset", {31'd0, memBus.memReq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        modelHalf = 16'd0;
        modelExt  = 1'b0;
        checkVal("asyncRstMemReq", {31'd0, memBus.memReq}, 32'd0);
        checkVal("asyncRstMemAddr", memBus.memAddr, 32'd0);
        checkVal("asyncRstHalfWord", {16'd0, halfWord}, 32'd0);
        checkVal("asyncRstOutputs", {27'd0, ExtHalf, loadDone, busy, loadErr, errCode}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        runLoad(32'h0000_6002, 1'b0, 32'hCAFE_BABE, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            runLoad($urandom(), 1'($urandom_range(0, 1)), $urandom(),
                    int'($urandom_range(0, 5)) - 1, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        checkVal("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/halfword_load_unit.md
HALFWORD_LOAD_UNIT -- requirements
Module: halfword_load_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles in REQ awaiting memReady before abort; legal range 2..255.
REQ-002 Parameter BIG_ENDIAN, default 0: 0 = address[1]=0 selects memRdata[15:0]; 1 = address[1]=0 selects memRdata[31:16].
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 startLoad  in  1  one-cycle request from MEM stage to load a half-word.
REQ-006 address  in  32  byte address of the half-word; sampled with startLoad.
REQ-007 extSign  in  1  1 = LH (sign-extend), 0 = LHU (zero-extend); sampled with startLoad.
REQ-008 memReq  out  1  data-memory read request.
REQ-009 memAddr  out  32  word-aligned read address.
REQ-010 memReady  in  1  memory has valid memRdata this cycle.
REQ-011 memRdata  in  32  read data word.
REQ-012 halfWord  out  16  selected half-word, feeds the half-word extender.
REQ-013 ExtHalf  out  1  extension mode for the extender; 1 = sign, 0 = zero.
REQ-014 loadDone  out  1  one-cycle pulse: halfWord/ExtHalf valid and updated.
REQ-015 busy  out  1  pipeline stall request.
REQ-016 loadErr  out  1  one-cycle error pulse.
REQ-017 errCode  out  1  0 = misaligned, 1 = timeout; valid when loadErr=1, otherwise held.

Function
REQ-018 FSM states IDLE, REQ, DONE, ERR; encoding free.
REQ-019 IDLE, startLoad=1, address[0]=0: latch address and extSign; go to REQ; clear wait counter.
REQ-020 IDLE, startLoad=1, address[0]=1: go to ERR with errCode=0; no memory request issued.
REQ-021 startLoad outside IDLE is ignored; no queuing.
REQ-022 REQ: memReq=1, memAddr={latched address[31:2],2'b00}; busy=1.
REQ-023 REQ, memReady=1: register the selected half of memRdata into halfWord, latched extSign into ExtHalf; go to DONE.
REQ-024 REQ, memReady=0: increment wait counter; when the counter reaches TIMEOUT-1 with memReady still 0, go to ERR with errCode=1.
REQ-025 memReady and the timeout in the same cycle: memReady wins; go to DONE.
REQ-026 DONE: loadDone=1 for exactly one cycle, busy=0, memReq=0; next state IDLE.
REQ-027 ERR: loadErr=1 for exactly one cycle, busy=0, memReq=0; halfWord and ExtHalf unchanged; next state IDLE.
REQ-028 busy=1 only in REQ; 0 in IDLE, DONE, ERR.
REQ-029 Half select: address[1] XOR BIG_ENDIAN = 0 selects memRdata[15:0], 1 selects memRdata[31:16].
REQ-030 halfWord and ExtHalf hold their last values until the next successful load.
REQ-031 memAddr is 0 whenever memReq=0.
REQ-032 Latency: startLoad to loadDone = 2 cycles with zero-wait memory, plus one cycle per wait cycle.
REQ-033 memReady outside REQ is ignored.

Reset
REQ-034 rst_n=0 immediately forces state IDLE, wait counter 0, memReq 0, memAddr 0, halfWord 0, ExtHalf 0, loadDone 0, busy 0, loadErr 0, errCode 0, independent of clk.
REQ-035 Reset during REQ abandons the transaction; no loadDone or loadErr is generated for it after release.
REQ-036 After rst_n deassertion the first rising edge is a normal IDLE cycle; startLoad in that cycle is accepted.

Verification
REQ-037 address=0x1002, extSign=1, memReady on first REQ cycle, memRdata=0x8001_1234 -> memAddr=0x1000, halfWord=0x8001, ExtHalf=1, loadDone 2 cycles after startLoad.
REQ-038 BIG_ENDIAN=0, address=0x2000, extSign=0, memReady after 3 wait cycles, memRdata=0xABCD_F00F -> halfWord=0xF00F, ExtHalf=0, busy high 4 cycles.
REQ-039 address=0x3001 -> loadErr pulse with errCode=0, memReq never asserted, halfWord unchanged.
REQ-040 TIMEOUT=4, memReady held 0 -> loadErr with errCode=1 after 4 REQ cycles; memReady raised on cycle 4 instead -> loadDone, no error.
REQ-041 rst_n low for 1 cycle mid-REQ -> memReq drops asynchronously, all outputs 0, no completion pulse; next load completes normally.
REQ-042 startLoad pulsed again during REQ with a different address -> ignored; only the first load completes.
